life_game_controller: RTL and testbench
=======================================

LIFE_GAME_CONTROLLER -- requirements
Module: life_game_controller

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 500000, meaning consecutive stable cycles required to accept a button level change.
REQ-002 The module SHALL have parameter SPEED_DEFAULT, default 4, meaning speed_level loaded at reset.
REQ-003 Port clock  input  1  sole clock; all logic on posedge clock.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port button  input  4  raw asynchronous buttons: [0] run/pause, [1] single step, [2] speed up, [3] clear.
REQ-006 Port frame_start  input  1  one-cycle pulse once per video frame, at start of vertical blank.
REQ-007 Port gen_advance  output  1  one-cycle pulse commanding the map datapath to compute one generation.
REQ-008 Port gen_clear  output  1  one-cycle pulse commanding the map datapath to empty the map.
REQ-009 Port running  output  1  high while in RUNNING state.
REQ-010 Port speed_level  output  3  current speed, 0 slowest to 7 fastest.
REQ-011 Port generation  output  16  generations advanced since reset or last clear.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debouncer that updates its stable level only after DEBOUNCE_CYCLES consecutive cycles of synchronized value differing from stable level.
REQ-013 A press event SHALL be a one-cycle pulse on the 0->1 transition of a stable level; release produces no event.
REQ-014 FSM states SHALL be PAUSED, RUNNING, STEP_PENDING, CLEAR_PENDING.
REQ-015 Clear press SHALL move any state to CLEAR_PENDING.
REQ-016 Run press SHALL toggle PAUSED<->RUNNING and is ignored in STEP_PENDING and CLEAR_PENDING.
REQ-017 Step press SHALL move PAUSED to STEP_PENDING and is ignored in other states.
REQ-018 Speed press SHALL increment speed_level in any state, wrapping 7->0, and zero the frame counter.
REQ-019 Simultaneous press events SHALL be prioritized clear > run > step; speed is applied independently of the others.
REQ-020 Frames per generation SHALL be 2^(7-speed_level): 1 at level 7, 128 at level 0.
REQ-021 In RUNNING, an 8-bit frame counter SHALL increment on each frame_start; on the frame_start where it equals period-1 it SHALL return to 0 and a generation is due.
REQ-022 The frame counter SHALL be zeroed on entry to PAUSED and on entry to RUNNING.
REQ-023 gen_advance SHALL assert for exactly one cycle, the cycle after the frame_start sample at which a generation is due (RUNNING) or in STEP_PENDING.
REQ-024 STEP_PENDING SHALL return to PAUSED in the same cycle gen_advance asserts.
REQ-025 In CLEAR_PENDING, gen_clear SHALL assert for one cycle after the next frame_start; the FSM then enters PAUSED and generation becomes 0.
REQ-026 generation SHALL increment by 1 with each gen_advance, wrapping 65535->0.
REQ-027 gen_advance and gen_clear SHALL never assert in the same cycle.
REQ-028 All outputs SHALL be registered; gen_advance/gen_clear never change outside one cycle after frame_start.

Reset
REQ-029 While reset is high on a clock edge: state PAUSED, speed_level SPEED_DEFAULT, generation 0, frame counter 0, gen_advance 0, gen_clear 0, running 0, synchronizers and stable levels 0, debounce counters 0.
REQ-030 Reset SHALL take effect from any state, including STEP_PENDING/CLEAR_PENDING, discarding the pending action with no pulse emitted.
REQ-031 A button held through reset deassertion SHALL generate a press event only after DEBOUNCE_CYCLES cycles.

Structure
REQ-032 Package life_game_pkg SHALL hold the FSM state enum, button index constants (BTN_RUN, BTN_STEP, BTN_SPEED, BTN_CLEAR) and SPEED_WIDTH=3.
REQ-033 Synchronizer, debouncer and edge detector SHALL form sub-module button_debounce, instantiated four times.

Verification (DEBOUNCE_CYCLES=4, frame_start every 100 cycles)
REQ-034 Reset, then run press, speed_level 7 -> gen_advance on cycle after every frame_start; generation 1,2,3 after three frames.
REQ-035 Default speed 4, running -> gen_advance every 8th frame; speed press -> level 5, frame counter zeroed, next pulse 4 frames later.
REQ-036 Paused, step press -> exactly one gen_advance after next frame_start, state PAUSED; step while RUNNING -> no extra pulse.
REQ-037 Button bounce 1-0-1 within 3 cycles -> no press event; held 4 cycles -> one event.
REQ-038 Clear and run pressed same cycle while RUNNING -> CLEAR_PENDING, one gen_clear after next frame_start, running 0, generation 0.
REQ-039 Speed presses from 7 -> speed_level 0; reset asserted in STEP_PENDING -> no gen_advance, speed_level 4.

Source files
------------

// File: rtl/life_game_pkg.sv
// ---------------------------------------------------------------------------
// life_game_pkg
// Shared definitions for the Game of Life control block:
//   - controller FSM state encoding
//   - button bit positions inside the 4-bit button bus
//   - speed field width and the frames-per-generation helper
// ---------------------------------------------------------------------------
package life_game_pkg;

    localparam int SPEED_WIDTH = 3;
    localparam int NUM_BUTTONS = 4;

    localparam int BTN_RUN   = 0;
    localparam int BTN_STEP  = 1;
    localparam int BTN_SPEED = 2;
    localparam int BTN_CLEAR = 3;

    typedef enum logic [1:0] {
        PAUSED        = 2'd0,
        RUNNING       = 2'd1,
        STEP_PENDING  = 2'd2,
        CLEAR_PENDING = 2'd3
    } ctrl_state_t;

    // Last frame-counter value of a generation period. The period is
    // 2^(7-level) frames, so the terminal count is that power of two minus 1
    // (127 at level 0, 0 at level 7).
    function automatic logic [7:0] period_last(input logic [SPEED_WIDTH-1:0] level);
        return (8'd1 << (3'd7 - level)) - 8'd1;
    endfunction

endpackage

// File: rtl/life_game_controller_if.sv
// ---------------------------------------------------------------------------
// life_game_controller_if
// Bundles the controller's user/video inputs and map-datapath outputs.
//   button[3:0]   raw buttons (run, step, speed, clear)
//   frame_start   one-cycle pulse per video frame
//   gen_advance   one-cycle "compute next generation" command
//   gen_clear     one-cycle "empty the map" command
//   running       high while the simulation free-runs
//   speed_level   current speed, 0 slowest .. 7 fastest
//   generation    generations advanced since reset or last clear
// master: the controller side.  slave: the environment / datapath side.
// ---------------------------------------------------------------------------
interface life_game_controller_if;
    import life_game_pkg::*;

    logic [NUM_BUTTONS-1:0] button;
    logic                   frame_start;
    logic                   gen_advance;
    logic                   gen_clear;
    logic                   running;
    logic [SPEED_WIDTH-1:0] speed_level;
    logic [15:0]            generation;

    modport master (
        input  button,
        input  frame_start,
        output gen_advance,
        output gen_clear,
        output running,
        output speed_level,
        output generation
    );

    modport slave (
        output button,
        output frame_start,
        input  gen_advance,
        input  gen_clear,
        input  running,
        input  speed_level,
        input  generation
    );

endinterface

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
// One raw button -> 2-flop synchronizer -> debouncer -> rising-edge pulse.
//   clock   sole clock
//   reset   synchronous, active-high
//   button  raw asynchronous button level
//   press   one-cycle pulse when the debounced level goes 0 -> 1
// The debounced level only follows the synchronized input after it has
// differed for DEBOUNCE_CYCLES consecutive cycles; any agreement in between
// restarts the count.
// ---------------------------------------------------------------------------
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             press_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg   <= '0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
            press_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], button};
            press_reg <= 1'b0;
            if (sync_reg[1] != stable_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    // Nth consecutive differing cycle: accept the new level.
                    stable_reg <= sync_reg[1];
                    cnt_reg    <= '0;
                    press_reg  <= sync_reg[1];
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/life_game_controller.sv
// ---------------------------------------------------------------------------
// life_game_controller
// Run/pause/step/clear/speed control for a Game of Life map datapath.
//   clock  sole clock, all logic on its rising edge
//   reset  synchronous, active-high
//   ctrl   life_game_controller_if.master (buttons, frame_start in;
//          gen_advance, gen_clear, running, speed_level, generation out)
// Commands to the datapath are only ever issued the cycle after a
// frame_start sample, so the map is updated during vertical blank.
// ---------------------------------------------------------------------------
module life_game_controller
    import life_game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SPEED_DEFAULT   = 4
) (
    input logic                    clock,
    input logic                    reset,
    life_game_controller_if.master ctrl
);

    logic [NUM_BUTTONS-1:0] press_evt;

    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clock  (clock),
                .reset  (reset),
                .button (ctrl.button[gi]),
                .press  (press_evt[gi])
            );
        end
    endgenerate

    ctrl_state_t            state_reg;
    logic [7:0]             frame_cnt_reg;
    logic [SPEED_WIDTH-1:0] speed_reg;
    logic [15:0]            gen_reg;
    logic                   gen_advance_reg;
    logic                   gen_clear_reg;
    logic                   running_reg;

    logic gen_due;
    assign gen_due = ctrl.frame_start && (frame_cnt_reg == period_last(speed_reg));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= PAUSED;
            frame_cnt_reg   <= '0;
            speed_reg       <= SPEED_WIDTH'(SPEED_DEFAULT);
            gen_reg         <= '0;
            gen_advance_reg <= 1'b0;
            gen_clear_reg   <= 1'b0;
            running_reg     <= 1'b0;
        end else begin
            gen_advance_reg <= 1'b0;
            gen_clear_reg   <= 1'b0;

            if (press_evt[BTN_CLEAR]) begin
                // Clear outranks everything, including a due generation.
                state_reg   <= CLEAR_PENDING;
                running_reg <= 1'b0;
            end else begin
                case (state_reg)
                    PAUSED: begin
                        if (press_evt[BTN_RUN]) begin
                            state_reg     <= RUNNING;
                            running_reg   <= 1'b1;
                            frame_cnt_reg <= '0;
                        end else if (press_evt[BTN_STEP]) begin
                            state_reg <= STEP_PENDING;
                        end
                    end
                    RUNNING: begin
                        if (press_evt[BTN_RUN]) begin
                            state_reg     <= PAUSED;
                            running_reg   <= 1'b0;
                            frame_cnt_reg <= '0;
                        end else if (gen_due) begin
                            gen_advance_reg <= 1'b1;
                            gen_reg         <= gen_reg + 16'd1;
                            frame_cnt_reg   <= '0;
                        end else if (ctrl.frame_start) begin
                            frame_cnt_reg <= frame_cnt_reg + 8'd1;
                        end
                    end
                    STEP_PENDING: begin
                        if (ctrl.frame_start) begin
                            gen_advance_reg <= 1'b1;
                            gen_reg         <= gen_reg + 16'd1;
                            state_reg       <= PAUSED;
                            frame_cnt_reg   <= '0;
                        end
                    end
                    CLEAR_PENDING: begin
                        if (ctrl.frame_start) begin
                            gen_clear_reg <= 1'b1;
                            gen_reg       <= '0;
                            state_reg     <= PAUSED;
                            frame_cnt_reg <= '0;
                        end
                    end
                    default: begin
                        state_reg   <= PAUSED;
                        running_reg <= 1'b0;
                    end
                endcase
            end

            // Speed is independent of the other buttons; placed last so its
            // counter restart wins over any frame-counter update above.
            if (press_evt[BTN_SPEED]) begin
                speed_reg     <= speed_reg + SPEED_WIDTH'(1);
                frame_cnt_reg <= '0;
            end
        end
    end

    assign ctrl.gen_advance = gen_advance_reg;
    assign ctrl.gen_clear   = gen_clear_reg;
    assign ctrl.running     = running_reg;
    assign ctrl.speed_level = speed_reg;
    assign ctrl.generation  = gen_reg;

endmodule

// File: tb/tb_life_game_controller.sv
// ---------------------------------------------------------------------------
// tb_life_game_controller
// Directed bench for life_game_controller with DEBOUNCE_CYCLES=4 and a
// frame_start pulse roughly every 100 cycles.
// ---------------------------------------------------------------------------
module tb_life_game_controller;
    import life_game_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    life_game_controller_if bus ();

    life_game_controller #(
        .DEBOUNCE_CYCLES (4),
        .SPEED_DEFAULT   (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ctrl  (bus)
    );

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int adv_seen = 0;
    int adv_exp  = 0;

    // Counts every gen_advance pulse so stray pulses between frames show up.
    always @(negedge clock) begin
        if (bus.gen_advance) adv_seen <= adv_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Hold the buttons long enough to pass sync + debounce, then release
    // long enough for the stable level to fall back to 0.
    task automatic press(input logic [3:0] m);
        bus.button = m;
        tick(8);
        bus.button = 4'b0000;
        tick(8);
    endtask

    // One video frame: pulse frame_start, check the command outputs in the
    // following cycle, check they are gone one cycle later, then idle.
    task automatic frame(input string tag, input logic exp_adv, input logic exp_clr);
        bus.frame_start = 1'b1;
        tick(1);
        bus.frame_start = 1'b0;
        check({tag, " adv"}, 32'(bus.gen_advance), 32'(exp_adv));
        check({tag, " clr"}, 32'(bus.gen_clear), 32'(exp_clr));
        if (exp_adv) adv_exp++;
        tick(1);
        check({tag, " width"}, 32'({bus.gen_advance, bus.gen_clear}), 32'd0);
        tick(98);
    endtask

    initial begin
        bus.button      = 4'b0001;   // run held through reset
        bus.frame_start = 1'b0;
        reset           = 1'b1;
        tick(3);
        check("rst running", 32'(bus.running), 32'd0);
        check("rst speed", 32'(bus.speed_level), 32'd4);
        check("rst generation", 32'(bus.generation), 32'd0);
        check("rst adv", 32'(bus.gen_advance), 32'd0);
        check("rst clr", 32'(bus.gen_clear), 32'd0);

        // Held run button: event only after sync + 4 debounce cycles.
        reset = 1'b0;
        tick(3);
        check("held early", 32'(bus.running), 32'd0);
        tick(6);
        check("held late", 32'(bus.running), 32'd1);
        bus.button = 4'b0000;
        tick(8);
        press(4'b0001);
        check("pause", 32'(bus.running), 32'd0);

        // Speed 7: one generation per frame.
        repeat (3) press(4'b0100);
        check("speed 7", 32'(bus.speed_level), 32'd7);
        press(4'b0001);
        check("run", 32'(bus.running), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            frame("lvl7 frame", 1'b1, 1'b0);
            check("lvl7 gen", 32'(bus.generation), 32'(i));
        end
        press(4'b0100);
        check("speed wrap 0", 32'(bus.speed_level), 32'd0);
        press(4'b0001);

        // Reset back to default speed 4: one generation every 8 frames.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("rst2 speed", 32'(bus.speed_level), 32'd4);
        check("rst2 generation", 32'(bus.generation), 32'd0);
        press(4'b0001);
        for (int i = 0; i < 7; i++) frame("lvl4 idle", 1'b0, 1'b0);
        frame("lvl4 due", 1'b1, 1'b0);
        check("lvl4 gen", 32'(bus.generation), 32'd1);
        frame("lvl4 after", 1'b0, 1'b0);
        press(4'b0100);
        check("speed 5", 32'(bus.speed_level), 32'd5);
        for (int i = 0; i < 3; i++) frame("lvl5 idle", 1'b0, 1'b0);
        frame("lvl5 due", 1'b1, 1'b0);
        check("lvl5 gen", 32'(bus.generation), 32'd2);

        // Step is ignored while running.
        press(4'b0010);
        frame("step running", 1'b0, 1'b0);
        check("step running state", 32'(bus.running), 32'd1);
        press(4'b0001);
        check("pause2", 32'(bus.running), 32'd0);

        // Single step while paused.
        press(4'b0010);
        frame("step", 1'b1, 1'b0);
        check("step gen", 32'(bus.generation), 32'd3);
        check("step running", 32'(bus.running), 32'd0);
        frame("step after", 1'b0, 1'b0);
        check("adv count a", 32'(adv_seen), 32'(adv_exp));

        // Bounce 1-0-1 is rejected; 4 held cycles is accepted once.
        bus.button = 4'b0001; tick(1);
        bus.button = 4'b0000; tick(1);
        bus.button = 4'b0001; tick(1);
        bus.button = 4'b0000; tick(10);
        check("bounce", 32'(bus.running), 32'd0);
        bus.button = 4'b0001; tick(4);
        bus.button = 4'b0000; tick(10);
        check("held 4", 32'(bus.running), 32'd1);

        // Clear + run together while running: clear wins.
        press(4'b1001);
        check("clr running", 32'(bus.running), 32'd0);
        check("clr gen before", 32'(bus.generation), 32'd3);
        frame("clear", 1'b0, 1'b1);
        check("clr gen", 32'(bus.generation), 32'd0);
        frame("clear after", 1'b0, 1'b0);
        press(4'b0001);
        check("post clr run", 32'(bus.running), 32'd1);
        press(4'b0001);

        // Speed 5 -> 6 -> 7 -> 0.
        repeat (3) press(4'b0100);
        check("speed 0", 32'(bus.speed_level), 32'd0);

        // Reset while a step is pending discards it.
        press(4'b0010);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        frame("rst step", 1'b0, 1'b0);
        check("rst3 speed", 32'(bus.speed_level), 32'd4);
        check("rst3 generation", 32'(bus.generation), 32'd0);
        check("rst3 running", 32'(bus.running), 32'd0);
        check("adv count b", 32'(adv_seen), 32'(adv_exp));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
